// File: rtl/sensor_avg_filter_if.sv
// Bundle of sample-side and average-side signals for sensor_avg_filter.
// master: the sensor/consumer side that drives samples and reads the mean.
// slave : the filter itself.
interface sensor_avg_filter_if #(
    parameter int W = 5
);
    logic         clr;
    logic [W-1:0] raw;
    logic         raw_vld;
    logic [W-1:0] avg;
    logic         avg_vld;
    logic         warm;
    logic         spike;

    modport master (
        output clr, raw, raw_vld,
        input  avg, avg_vld, warm, spike
    );

    modport slave (
        input  clr, raw, raw_vld,
        output avg, avg_vld, warm, spike
    );
endinterface

// File: rtl/sensor_avg_filter.sv
// sensor_avg_filter: sliding-window mean of the last 2^DEPTH_LOG2 accepted
// samples, used to de-noise the input of the threshold/hysteresis FSM.
// Optional spike rejection is enabled by defining SENSOR_AVG_SPIKE_REJECT_EN.
// Without that macro every strobed sample is accepted and spike is tied low.
module sensor_avg_filter #(
    parameter int W          = 5,
    parameter int DEPTH_LOG2 = 2,
    parameter int SPIKE_TH   = 8,
    parameter int MAX_REJ    = 3
) (
    input  logic              clk,
    input  logic              rst,
    sensor_avg_filter_if.slave bus
);
    localparam int N  = 1 << DEPTH_LOG2;
    localparam int SW = W + DEPTH_LOG2;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [DEPTH_LOG2-1:0] FILL_LAST = DEPTH_LOG2'(N - 1);

    // Reject configurations the datapath cannot represent.
    if (DEPTH_LOG2 < 1 || W < 1 || SPIKE_TH < 0 || MAX_REJ < 0) begin : g_bad_cfg
        $error("sensor_avg_filter: invalid parameter set");
    end

    logic [W-1:0]          win [N];
    logic [SW-1:0]         sum;
    logic [SW-1:0]         next_sum;
    logic [W-1:0]          avg_next;
    logic [DEPTH_LOG2-1:0] fill_cnt;
    logic [0:0]            state;
    logic [W-1:0]          avg_q;
    logic                  avg_vld_q;
    logic                  reject;
    logic                  accept;

    // New running sum if the current sample were pushed into the window.
    always_comb begin
        next_sum = sum + SW'(bus.raw) - SW'(win[N-1]);
        avg_next = next_sum[SW-1:DEPTH_LOG2];
        accept   = bus.raw_vld && !bus.clr && !reject;
    end

`ifdef SENSOR_AVG_SPIKE_REJECT_EN
    localparam int RW = (MAX_REJ > 0) ? $clog2(MAX_REJ + 1) : 1;

    logic signed [W:0] diff;
    logic [W:0]        mag;
    logic              out_of_range;
    logic [RW-1:0]     rej_cnt;
    logic              spike_q;

    // Distance of the raw sample from the registered mean and the reject decision.
    always_comb begin
        diff         = $signed({1'b0, bus.raw}) - $signed({1'b0, avg_q});
        mag          = diff[W] ? $unsigned(-diff) : $unsigned(diff);
        out_of_range = int'(mag) > SPIKE_TH;
        reject       = bus.raw_vld && !bus.clr && (state == RUN) && out_of_range
                       && (rej_cnt != RW'(MAX_REJ));
    end

    // Count consecutive rejected spikes; any accepted sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_cnt <= '0;
            spike_q <= 1'b0;
        end else if (bus.clr) begin
            rej_cnt <= '0;
            spike_q <= 1'b0;
        end else begin
            spike_q <= reject;
            if (reject) begin
                rej_cnt <= rej_cnt + 1'b1;
            end else if (accept) begin
                rej_cnt <= '0;
            end
        end
    end

    assign bus.spike = spike_q;
`else
    assign reject    = 1'b0;
    assign bus.spike = 1'b0;
`endif

    // Window, running sum, fill tracking and the registered mean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                win[i] <= '0;
            end
            sum       <= '0;
            fill_cnt  <= '0;
            state     <= FILL;
            avg_q     <= '0;
            avg_vld_q <= 1'b0;
        end else if (bus.clr) begin
            for (int i = 0; i < N; i++) begin
                win[i] <= '0;
            end
            sum       <= '0;
            fill_cnt  <= '0;
            state     <= FILL;
            avg_vld_q <= 1'b0;
        end else if (accept) begin
            win[0] <= bus.raw;
            for (int i = 1; i < N; i++) begin
                win[i] <= win[i-1];
            end
            sum <= next_sum;
            if (state == FILL) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (fill_cnt == FILL_LAST) begin
                    state     <= RUN;
                    avg_q     <= avg_next;
                    avg_vld_q <= 1'b1;
                end else begin
                    avg_vld_q <= 1'b0;
                end
            end else begin
                avg_q     <= avg_next;
                avg_vld_q <= 1'b1;
            end
        end else begin
            avg_vld_q <= 1'b0;
        end
    end

    assign bus.avg     = avg_q;
    assign bus.avg_vld = avg_vld_q;
    assign bus.warm    = (state == RUN);
endmodule

// File: doc/sensor_avg_filter.md
Name: sensor_avg_filter

Overview:
- Upstream conditioning stage for the 5-bit threshold/hysteresis FSM.
- Accepts raw 5-bit sensor samples qualified by a valid strobe and keeps a sliding window of the last 2^DEPTH_LOG2 accepted samples.
- Emits the truncated window mean as a 5-bit value with a one-cycle valid pulse, so noise does not chatter the downstream FSM between states.

Parameters:
- W, 5: sample and average width.
- DEPTH_LOG2, 2: log2 of window length (default window N = 4).
- SPIKE_TH, 8: maximum allowed |raw - avg| before a sample counts as a spike (used only with the optional feature).
- MAX_REJ, 3: consecutive spikes dropped before a step change is accepted (used only with the optional feature).

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- clr, input, 1: synchronous window flush.
- raw, input, W: raw sensor sample.
- raw_vld, input, 1: raw is valid this cycle; single-cycle strobe, no backpressure.
- avg, output, W: registered window mean; holds its value between updates.
- avg_vld, output, 1: one-cycle pulse marking a new avg.
- warm, output, 1: high once the window is full.
- spike, output, 1: one-cycle pulse when a sample is rejected; tied 0 without the optional feature.

Behaviour:
- Reset (async, rst=1):
  - Window registers, running sum, fill counter and reject counter all go to 0.
  - avg=0, avg_vld=0, warm=0, spike=0, state=FILL.
  - A reset mid-operation discards all history; a full refill is required afterwards.
- Sum width is W+DEPTH_LOG2 (7 bits at defaults). Max sum is 31*4=124, so no overflow is possible.
- Accepted sample at edge k:
  - sum <= sum + raw - oldest.
  - Window shifts by one position and the oldest sample is discarded.
  - avg <= (sum + raw - oldest) >> DEPTH_LOG2, truncating (floor), no rounding.
- Latency: avg and avg_vld update on the same edge that accepts the sample. avg_vld is high for exactly the one following cycle.
- State machine:
  - FILL: each raw_vld sample is accepted and the fill counter increments; avg_vld stays 0.
    - On the N-th accepted sample: go to RUN, set warm=1, pulse avg_vld with the mean of those N samples.
  - RUN: every accepted sample produces an avg_vld pulse; warm stays 1.
- clr=1 at an edge:
  - Same clearing as reset, but synchronous; state returns to FILL and warm goes to 0.
  - avg keeps its last value; avg_vld=0 that cycle.
  - clr together with raw_vld: clr wins and the sample is dropped.
- raw_vld=0: no state change. avg holds, avg_vld=0, spike=0.
- Back-to-back raw_vld on consecutive cycles is fully supported; one sample is accepted per cycle.

Optional Feature:
- Macro: SENSOR_AVG_SPIKE_REJECT_EN.
- Defined: in RUN, a raw_vld sample with |raw - avg| > SPIKE_TH is rejected.
  - Rejected: no window push, no avg_vld, spike pulses for one cycle, reject counter increments.
  - If the reject counter already equals MAX_REJ, the out-of-range sample is accepted as a genuine step change.
  - Any accepted sample clears the reject counter; clr and rst also clear it.
  - The comparison uses the registered avg at W+1-bit signed width.
  - No rejection happens in FILL.
- Undefined: every raw_vld sample is accepted, spike is constant 0, and the reject counter is not instantiated.

Test Plan:
- Reset, then raw=20 for 4 strobes -> avg_vld first pulses after the 4th strobe with avg=20, warm=1. Then raw=24 -> avg=21 (sum 84).
- Window 0,0,0,3 -> avg=0 (truncation). Then four samples of 31 -> avg=31 (sum 124), no wrap.
- After 2 accepted samples, pulse rst mid-window -> all outputs 0. Exactly 4 new strobes are needed before the next avg_vld.
- In RUN, assert clr together with raw_vld (raw=31) -> sample dropped, avg_vld=0, warm=0, avg unchanged. 4 further strobes are needed before avg_vld.
- raw_vld high for 6 consecutive cycles with raw=8 after warm-up at avg 16 -> avg_vld high in 6 consecutive cycles with avg 14, 12, 10, 8, 8, 8.
- With SENSOR_AVG_SPIKE_REJECT_EN, at avg=20 send raw=31 four times:
  - First three -> spike pulses, avg stays 20, no avg_vld.
  - Fourth -> accepted, avg=22 (91/4).
  - Repeat the same stimulus with the macro undefined -> all four accepted, spike stays 0.
